// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared state encodings and requester count for the round-robin arbiter
package mux_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int NREQ = 4;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/consumer bundle between the arbiter and its environment
interface mux_rr_arbiter_if #(
  parameter int W = 8
);
  import mux_rr_arbiter_pkg::*;

  logic [NREQ-1:0] req;
  logic [W-1:0]    d0;
  logic [W-1:0]    d1;
  logic [W-1:0]    d2;
  logic [W-1:0]    d3;
  logic            out_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [NREQ-1:0] gnt;
  logic [1:0]      sel;
  logic [NREQ-1:0] ack;

  // master: requesters plus consumer side; slave: the arbiter
  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  out_valid, out_data, gnt, sel, ack
  );

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output out_valid, out_data, gnt, sel, ack
  );

endinterface

// File: rtl/mux_rr_arbiter_mux4_data.sv
// rtl/mux_rr_arbiter_mux4_data.sv - combinational 4:1 W-bit data multiplexer
module mux4_data #(
  parameter int W = 8
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  input  logic [1:0]   sel,
  output logic [W-1:0] o
);

  always_comb begin
    case (sel)
      2'd0:    o = i0;
      2'd1:    o = i1;
      2'd2:    o = i2;
      default: o = i3;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - four-way round-robin arbiter with bounded bursts driving a shared valid/ready channel
module mux_rr_arbiter #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus
);
  import mux_rr_arbiter_pkg::*;

  localparam int             CW   = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0]  LAST = CW'(BURST - 1);

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [1:0]      r_sel, w_sel_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic            w_found;
  logic [1:0]      w_winner;
  logic [1:0]      w_idx;
  logic            w_valid;
  logic            w_xfer;
  logic [W-1:0]    w_mux;

  // priority scan starts at ptr and wraps 3->0
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_valid = (r_state == ST_GRANT) && bus.req[r_sel];
  assign w_xfer  = w_valid && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = NREQ'(1) << w_winner;
          w_sel_nxt   = w_winner;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        // a final beat and a withdrawal both release with the same pointer advance
        if ((w_xfer && r_cnt == LAST) || !bus.req[r_sel]) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_sel + 2'd1;
          w_cnt_nxt   = '0;
        end else if (w_xfer) begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  mux4_data #(.W(W)) u_mux (
    .i0  (bus.d0),
    .i1  (bus.d1),
    .i2  (bus.d2),
    .i3  (bus.d3),
    .sel (r_sel),
    .o   (w_mux)
  );

  assign bus.out_valid = w_valid;
  assign bus.out_data  = (r_state == ST_GRANT) ? w_mux : '0;
  assign bus.ack       = w_xfer ? (NREQ'(1) << r_sel) : '0;
  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter sharing one W-bit output channel among four requesters. It owns the select of a 4:1 data multiplexer and sequences grants with a valid/ready handshake toward the consumer. Bursts are bounded so no requester holds the channel for more than BURST beats. It sits between the requesting blocks and the single shared consumer path that the team's 2:1 and 4:1 mux blocks feed.

## Interface
Parameters:
- W, 8, data width of each requester input and of out_data
- BURST, 4, maximum beats per grant (≥1); beat counter width is clog2(BURST), minimum 1

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request per requester; held high while data is offered
- d0, d1, d2, d3  input  W each  requester data
- out_ready  input  1  consumer accepts the current beat
- out_valid  output  1  beat offered to the consumer
- out_data  output  W  data of the granted requester
- gnt  output  4  one-hot grant, registered
- sel  output  2  mux select, registered, encoding of gnt
- ack  output  4  one-hot beat-accepted strobe to the granted requester

## Operation
- States: IDLE, GRANT. State, gnt, sel, ptr (2-bit priority pointer) and beat_cnt are registered.
- IDLE:
  - Scan req starting at index ptr, wrapping 3→0, and pick the first high bit.
  - If one is found, load gnt/sel with the winner, clear beat_cnt, and go to GRANT.
  - If none is found, stay in IDLE.
- GRANT:
  - out_valid = req[sel]; out_data = d[sel] (combinational via the mux).
  - Transfer occurs when out_valid && out_ready. ack[sel] = 1 in that cycle only.
  - On a transfer with beat_cnt == BURST-1: release.
  - On a transfer otherwise: beat_cnt increments and the grant is kept.
  - req[sel] low (withdrawal, no transfer): release.
- Release: ptr ← sel+1 mod 4, gnt ← 0, beat_cnt ← 0, next state IDLE. There is always one idle bubble between grants.
- Outside GRANT: out_valid = 0, out_data = 0, ack = 0.
- Requests from non-granted requesters are ignored until the next IDLE scan; they are not latched.
- Reset values: state IDLE, gnt 0, sel 0, ptr 0, beat_cnt 0. Hence out_valid 0, out_data 0, ack 0.
- Reset asserted mid-burst aborts immediately. The partial burst is not resumed and there is no ack for the aborted beat.

## Timing
- Latency from req high (sampled at edge N in IDLE) to gnt/sel/out_valid high after edge N: 1 cycle.
- out_valid, out_data and ack are combinational from registered state, req[sel], out_ready and d*. There is no combinational path from any req[i≠sel].
- out_ready low stalls the beat with out_data stable, provided the requester holds d; beat_cnt does not advance.
- Back-to-back beats: one per cycle while out_ready is high.
- Grant turnaround: the last beat at edge N is followed by IDLE in cycle N+1 and the next grant after edge N+1. The minimum gap is 1 cycle with out_valid low.
- Simultaneous requests resolve purely by ptr. Worst-case wait is 3 grants × (BURST+1) cycles.

## Structure
- Shared definitions file holds:
  - state encodings ST_IDLE = 1'b0, ST_GRANT = 1'b1
  - requester count localparam NREQ = 4
- Sub-module mux4_data: a combinational 4:1 W-bit mux (i0..i3, sel, o). It is instantiated once for out_data and gated with the GRANT state.
- The round-robin priority scan is a function or always block inside the top. No further sub-modules.

## Test plan
- Reset: hold rst_n low, drive req=4'b1111 → gnt 0, out_valid 0, out_data 0. First grant after release goes to requester 0.
- Single requester, BURST=4: req=4'b0100, d2=8'hA5, out_ready=1 →
  - gnt=4'b0100, sel=2 one cycle later.
  - 4 beats of A5, with ack[2] high on each.
  - Then 1 idle cycle; after it, gnt returns to 4'b0100 for the next burst.
- Round-robin fairness: req=4'b1111 held, out_ready=1 → grant order 0,1,2,3,0, each 4 beats with a 1-cycle gap.
- Backpressure: granted requester 1, out_ready low for 3 cycles mid-burst → out_data=d1 stable, ack 0, beat_cnt frozen. The burst completes with 4 total acks.
- Withdrawal: requester 3 granted, drops req after 2 beats → out_valid falls the same cycle, IDLE next, ptr=0. Pending req[0] is granted one cycle later.
- Async reset mid-burst: pull rst_n low between edges during beat 2 → gnt, out_valid and ack go to 0 immediately, without waiting for a clock edge. After release with req=4'b0010, the first grant goes to requester 1.
